// File: rtl/carfield_addr_map_rt.sv
// Runtime-programmable address map: shadow/active rule tables, 32-bit config port, registered decode.
// Latency: decode result one cycle after acceptance; config access completes in the request cycle.
// Backpressure: decode input stalls on a held output, an outstanding-count limit or a pending commit.
//   Shadow writes stall only during the one-cycle table swap.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cfg_*                   register access (valid/ready, zero wait states except shadow writes during SWAP)
//   dec_valid_i/ready_o     decode request handshake, dec_addr_i address to decode
//   dec_out_*/dec_idx_o     registered decode result (target index, dec_err_o = no rule matched)
//   done_i                  one decoded transaction has completed downstream
//   commit_done_o           one-cycle pulse in the first cycle the new active table is in use
module carfield_addr_map_rt #(
  parameter int NumRules       = 8,
  parameter int AddrWidth      = 48,
  parameter int IdxWidth       = 4,
  parameter int DefaultIdx     = 0,
  parameter int MaxOutstanding = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  input  logic                 cfg_write_i,
  input  logic [8:0]           cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_ready_o,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_error_o,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [AddrWidth-1:0] dec_addr_i,
  output logic                 dec_out_valid_o,
  input  logic                 dec_out_ready_i,
  output logic [IdxWidth-1:0]  dec_idx_o,
  output logic                 dec_err_o,
  input  logic                 done_i,
  output logic                 commit_done_o
);

  localparam int HiW  = AddrWidth - 32;
  localparam int CntW = $clog2(MaxOutstanding) + 1;
  localparam logic [CntW-1:0] MaxCnt      = CntW'(MaxOutstanding);
  localparam logic [4:0]      NumRulesW   = 5'(NumRules);

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;

  state_e state_q;
  logic   commit_done_q;

  // Rule tables: shadow is written by software, active is used by the decoder.
  logic [AddrWidth-1:0] sh_start_q  [NumRules];
  logic [AddrWidth-1:0] sh_end_q    [NumRules];
  logic                 sh_en_q     [NumRules];
  logic [IdxWidth-1:0]  sh_idx_q    [NumRules];
  logic [AddrWidth-1:0] act_start_q [NumRules];
  logic [AddrWidth-1:0] act_end_q   [NumRules];
  logic                 act_en_q    [NumRules];
  logic [IdxWidth-1:0]  act_idx_q   [NumRules];

  logic                dec_vld_q, dec_err_q;
  logic [IdxWidth-1:0] dec_idx_q;
  logic [CntW-1:0]     cnt_q, cnt_d;

  // ---------------- config address decode ----------------
  logic       aligned, is_ctrl, is_stat, rule_ok, map_hit;
  logic [3:0] rsel;
  logic [2:0] roff;

  assign rsel    = cfg_addr_i[8:5];
  assign roff    = cfg_addr_i[4:2];
  assign aligned = (cfg_addr_i[1:0] == 2'b00);
  assign is_ctrl = (cfg_addr_i == 9'h100);
  assign is_stat = (cfg_addr_i == 9'h104);
  // CTRL/STATUS take precedence over a rule slot that would alias them (only if NumRules > 8).
  assign rule_ok = aligned && !is_ctrl && !is_stat && ({1'b0, rsel} < NumRulesW) && (roff <= 3'd4);
  assign map_hit = is_ctrl || is_stat || rule_ok;

  logic shadow_wr, shadow_stall, shadow_we, commit_req;
  assign shadow_wr    = cfg_valid_i && cfg_write_i && rule_ok;
  // The swap copies the shadow table this cycle, so hold writes until it is done.
  assign shadow_stall = shadow_wr && (state_q == SWAP);
  assign shadow_we    = shadow_wr && !shadow_stall;
  assign commit_req   = cfg_valid_i && cfg_write_i && is_ctrl && cfg_wdata_i[0];

  assign cfg_ready_o = cfg_valid_i && !shadow_stall;
  assign cfg_error_o = cfg_valid_i && !map_hit;

  logic [31:0] rd_rule, status;
  assign status = {16'h0, 8'(cnt_q), 7'h0, (state_q != IDLE)};

  always_comb begin
    rd_rule = '0;
    for (int i = 0; i < NumRules; i++) begin
      if (rsel == 4'(i)) begin
        case (roff)
          3'd0:    rd_rule = sh_start_q[i][31:0];
          3'd1:    rd_rule = 32'(sh_start_q[i][AddrWidth-1:32]);
          3'd2:    rd_rule = sh_end_q[i][31:0];
          3'd3:    rd_rule = 32'(sh_end_q[i][AddrWidth-1:32]);
          3'd4:    rd_rule = {sh_en_q[i], {(31-IdxWidth){1'b0}}, sh_idx_q[i]};
          default: rd_rule = '0;
        endcase
      end
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_valid_i && !cfg_write_i) begin
      if (is_stat)      cfg_rdata_o = status;
      else if (rule_ok) cfg_rdata_o = rd_rule;
    end
  end

  // ---------------- shadow table ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRules; i++) begin
        sh_start_q[i] <= '0;
        sh_end_q[i]   <= '0;
        sh_en_q[i]    <= 1'b0;
        sh_idx_q[i]   <= '0;
      end
    end else if (shadow_we) begin
      for (int i = 0; i < NumRules; i++) begin
        if (rsel == 4'(i)) begin
          case (roff)
            3'd0: sh_start_q[i][31:0]          <= cfg_wdata_i;
            3'd1: sh_start_q[i][AddrWidth-1:32] <= cfg_wdata_i[HiW-1:0];
            3'd2: sh_end_q[i][31:0]            <= cfg_wdata_i;
            3'd3: sh_end_q[i][AddrWidth-1:32]   <= cfg_wdata_i[HiW-1:0];
            3'd4: begin
              sh_en_q[i]  <= cfg_wdata_i[31];
              sh_idx_q[i] <= cfg_wdata_i[IdxWidth-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- active table ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRules; i++) begin
        act_start_q[i] <= '0;
        act_end_q[i]   <= '0;
        act_en_q[i]    <= 1'b0;
        act_idx_q[i]   <= '0;
      end
    end else if (state_q == SWAP) begin
      for (int i = 0; i < NumRules; i++) begin
        act_start_q[i] <= sh_start_q[i];
        act_end_q[i]   <= sh_end_q[i];
        act_en_q[i]    <= sh_en_q[i];
        act_idx_q[i]   <= sh_idx_q[i];
      end
    end
  end

  // ---------------- decode ----------------
  logic [IdxWidth-1:0] match_idx;
  logic                match_err;

  // Scan from the highest rule down so the lowest-numbered match is assigned last and wins.
  // An empty or inverted range (end <= start) can never satisfy both bounds.
  always_comb begin
    match_idx = IdxWidth'(DefaultIdx);
    match_err = 1'b1;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (act_en_q[i] && (dec_addr_i >= act_start_q[i]) && (dec_addr_i < act_end_q[i])) begin
        match_idx = act_idx_q[i];
        match_err = 1'b0;
      end
    end
  end

  logic dec_accept, out_hs, cnt_dec;
  assign dec_ready_o = (!dec_vld_q || dec_out_ready_i) && (state_q == IDLE) && (cnt_q < MaxCnt);
  assign dec_accept  = dec_valid_i && dec_ready_o;
  assign out_hs      = dec_vld_q && dec_out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_vld_q <= 1'b0;
      dec_idx_q <= '0;
      dec_err_q <= 1'b0;
    end else if (dec_accept) begin
      dec_vld_q <= 1'b1;
      dec_idx_q <= match_idx;
      dec_err_q <= match_err;
    end else if (out_hs) begin
      dec_vld_q <= 1'b0;
    end
  end

  assign dec_out_valid_o = dec_vld_q;
  assign dec_idx_o       = dec_idx_q;
  assign dec_err_o       = dec_err_q;

  // ---------------- outstanding counter ----------------
  // A completion with nothing outstanding is dropped rather than wrapping the counter.
  assign cnt_dec = done_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs && !cnt_dec)      cnt_d = cnt_q + 1'b1;
    else if (!out_hs && cnt_dec) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // ---------------- commit FSM ----------------
  // The done pulse is raised in the cycle after SWAP, i.e. the first cycle decodes see the new table.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      commit_done_q <= 1'b0;
    end else begin
      commit_done_q <= (state_q == SWAP);
      case (state_q)
        IDLE:    if (commit_req) state_q <= DRAIN;
        DRAIN:   if (!dec_vld_q && (cnt_q == '0)) state_q <= SWAP;
        SWAP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign commit_done_o = commit_done_q;

endmodule

// File: tb/tb_carfield_addr_map_rt.sv
// Directed testbench for carfield_addr_map_rt (instantiated with NumRules=7).
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 ns after the rising edge.
// Each test task compares against hand-computed values and reports a summary at the end.
module tb_carfield_addr_map_rt;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_valid_i, cfg_write_i;
  logic [8:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic        cfg_ready_o, cfg_error_o;
  logic [31:0] cfg_rdata_o;
  logic        dec_valid_i, dec_ready_o;
  logic [47:0] dec_addr_i;
  logic        dec_out_valid_o, dec_out_ready_i;
  logic [3:0]  dec_idx_o;
  logic        dec_err_o, done_i, commit_done_o;

  int checks = 0;
  int passed = 0;
  int pulses = 0;

  carfield_addr_map_rt #(.NumRules(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_write_i(cfg_write_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_ready_o(cfg_ready_o), .cfg_rdata_o(cfg_rdata_o),
    .cfg_error_o(cfg_error_o),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_addr_i(dec_addr_i),
    .dec_out_valid_o(dec_out_valid_o), .dec_out_ready_i(dec_out_ready_i),
    .dec_idx_o(dec_idx_o), .dec_err_o(dec_err_o),
    .done_i(done_i), .commit_done_o(commit_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (commit_done_o === 1'b1) pulses++;

  task automatic cfg_acc(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output logic rdy);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_write_i = wr; cfg_addr_i = a; cfg_wdata_i = wd;
    #1;
    rd = cfg_rdata_o; er = cfg_error_o; rdy = cfg_ready_o;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_write_i = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    logic [31:0] r; logic e, y;
    cfg_acc(1'b1, a, d, r, e, y);
  endtask

  task automatic rd(input logic [8:0] a, output logic [31:0] d);
    logic e, y;
    cfg_acc(1'b0, a, 32'h0, d, e, y);
  endtask

  // One decode with dec_out_ready_i high; returns after the output handshake.
  task automatic do_decode(input logic [47:0] a, output logic [3:0] idx, output logic er);
    int n = 0;
    @(negedge clk_i);
    dec_valid_i = 1'b1; dec_addr_i = a;
    #1;
    while (!dec_ready_o && n < 40) begin @(negedge clk_i); #1; n++; end
    if (!dec_ready_o) begin
      checks++;
      $display("FAIL decode_accept_timeout: dec_ready_o=%b want 1", dec_ready_o);
    end
    @(posedge clk_i); #1;
    dec_valid_i = 1'b0;
    idx = dec_idx_o; er = dec_err_o;
    checks++; if (dec_out_valid_o !== 1'b1) $display("FAIL dec_out_valid: got %b want 1", dec_out_valid_o); else passed++;
    @(posedge clk_i); #1;
  endtask

  task automatic send_done();
    @(negedge clk_i); done_i = 1'b1;
    @(posedge clk_i); #1; done_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (commit_done_o !== 1'b0) $display("FAIL rst_commit_done: got %b want 0", commit_done_o); else passed++;
    checks++; if (dec_out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", dec_out_valid_o); else passed++;
    rst_i = 1'b0; #1;
    checks++; if (dec_ready_o !== 1'b1) $display("FAIL rst_dec_ready: got %b want 1", dec_ready_o); else passed++;
    rd(9'h104, r);
    checks++; if (r !== 32'h0) $display("FAIL rst_status: got %h want 0", r); else passed++;
    rd(9'h010, r);
    checks++; if (r !== 32'h0) $display("FAIL rst_rule0_cfg: got %h want 0", r); else passed++;
  endtask

  task automatic test_default_decode();
    logic [3:0] i; logic e;
    do_decode(48'h0000_8000_0000, i, e);
    checks++; if (i !== 4'd0 || e !== 1'b1) $display("FAIL default_decode: got idx=%0d err=%b want idx=0 err=1", i, e); else passed++;
    send_done();
  endtask

  task automatic test_rule_match();
    logic [3:0] i; logic e; logic [31:0] r; int p0;
    wr(9'h000, 32'h8000_0000); wr(9'h004, 32'h0);
    wr(9'h008, 32'h0);         wr(9'h00C, 32'h1);
    wr(9'h010, 32'h8000_0003);
    rd(9'h00C, r);
    checks++; if (r !== 32'h1) $display("FAIL rule0_endhi_rb: got %h want 1", r); else passed++;
    rd(9'h010, r);
    checks++; if (r !== 32'h8000_0003) $display("FAIL rule0_cfg_rb: got %h want 80000003", r); else passed++;
    do_decode(48'h0000_9000_0000, i, e); send_done();
    checks++; if (e !== 1'b1) $display("FAIL shadow_not_active: got err=%b want 1", e); else passed++;
    p0 = pulses;
    wr(9'h100, 32'h1);
    repeat (8) @(posedge clk_i); #1;
    checks++; if (pulses - p0 !== 1) $display("FAIL commit1_pulses: got %0d want 1", pulses - p0); else passed++;
    do_decode(48'h0000_9000_0000, i, e); send_done();
    checks++; if (i !== 4'd3 || e !== 1'b0) $display("FAIL match_mid: got idx=%0d err=%b want idx=3 err=0", i, e); else passed++;
    do_decode(48'h0001_0000_0000, i, e); send_done();
    checks++; if (i !== 4'd0 || e !== 1'b1) $display("FAIL end_exclusive: got idx=%0d err=%b want idx=0 err=1", i, e); else passed++;
    do_decode(48'h0000_8000_0000, i, e); send_done();
    checks++; if (i !== 4'd3 || e !== 1'b0) $display("FAIL start_inclusive: got idx=%0d err=%b want idx=3 err=0", i, e); else passed++;
    do_decode(48'h0000_7FFF_FFFF, i, e); send_done();
    checks++; if (e !== 1'b1) $display("FAIL below_start: got err=%b want 1", e); else passed++;
  endtask

  task automatic test_overlap();
    logic [3:0] i; logic e; int p0;
    wr(9'h020, 32'h0); wr(9'h024, 32'h0);
    wr(9'h028, 32'hFFFF_FFFF); wr(9'h02C, 32'h0000_FFFF);
    wr(9'h030, 32'h8000_0005);
    p0 = pulses;
    wr(9'h100, 32'h1);
    repeat (8) @(posedge clk_i); #1;
    checks++; if (pulses - p0 !== 1) $display("FAIL commit2_pulses: got %0d want 1", pulses - p0); else passed++;
    do_decode(48'h0000_8000_0000, i, e); send_done();
    checks++; if (i !== 4'd3 || e !== 1'b0) $display("FAIL overlap_lowest: got idx=%0d err=%b want idx=3 err=0", i, e); else passed++;
    do_decode(48'h0000_0000_1000, i, e); send_done();
    checks++; if (i !== 4'd5 || e !== 1'b0) $display("FAIL overlap_rule1: got idx=%0d err=%b want idx=5 err=0", i, e); else passed++;
    do_decode(48'hFFFF_FFFF_FFFE, i, e); send_done();
    checks++; if (i !== 4'd5 || e !== 1'b0) $display("FAIL rule1_top: got idx=%0d err=%b want idx=5 err=0", i, e); else passed++;
    do_decode(48'hFFFF_FFFF_FFFF, i, e); send_done();
    checks++; if (i !== 4'd0 || e !== 1'b1) $display("FAIL rule1_end: got idx=%0d err=%b want idx=0 err=1", i, e); else passed++;
  endtask

  task automatic test_commit_drain();
    logic [3:0] i; logic e; logic [31:0] r; int p0;
    wr(9'h010, 32'h8000_0009);
    do_decode(48'h0000_9000_0000, i, e);
    checks++; if (i !== 4'd3) $display("FAIL pre_commit_old_a: got idx=%0d want 3", i); else passed++;
    do_decode(48'h0000_9000_0000, i, e);
    checks++; if (i !== 4'd3) $display("FAIL pre_commit_old_b: got idx=%0d want 3", i); else passed++;
    p0 = pulses;
    wr(9'h100, 32'h1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL drain_ready: got %b want 0", dec_ready_o); else passed++;
    rd(9'h104, r);
    checks++; if (r !== 32'h201) $display("FAIL drain_status: got %h want 201", r); else passed++;
    wr(9'h100, 32'h1);
    rd(9'h104, r);
    checks++; if (r !== 32'h201) $display("FAIL drain_recommit: got %h want 201", r); else passed++;
    repeat (5) @(posedge clk_i); #1;
    checks++; if (pulses - p0 !== 0) $display("FAIL drain_early_pulse: got %0d want 0", pulses - p0); else passed++;
    send_done();
    rd(9'h104, r);
    checks++; if (r !== 32'h101) $display("FAIL drain_status1: got %h want 101", r); else passed++;
    send_done();
    repeat (8) @(posedge clk_i); #1;
    checks++; if (pulses - p0 !== 1) $display("FAIL drain_commit_pulses: got %0d want 1", pulses - p0); else passed++;
    rd(9'h104, r);
    checks++; if (r !== 32'h0) $display("FAIL post_commit_status: got %h want 0", r); else passed++;
    do_decode(48'h0000_9000_0000, i, e); send_done();
    checks++; if (i !== 4'd9 || e !== 1'b0) $display("FAIL post_commit_new: got idx=%0d err=%b want idx=9 err=0", i, e); else passed++;
  endtask

  task automatic test_cfg_error();
    logic [31:0] r; logic e, y;
    cfg_acc(1'b0, 9'h0E0, 32'h0, r, e, y);
    checks++; if (e !== 1'b1 || r !== 32'h0 || y !== 1'b1) $display("FAIL err_rule7_rd: got err=%b rdata=%h rdy=%b want 1 0 1", e, r, y); else passed++;
    cfg_acc(1'b1, 9'h0E0, 32'hDEAD_BEEF, r, e, y);
    checks++; if (e !== 1'b1) $display("FAIL err_rule7_wr: got err=%b want 1", e); else passed++;
    cfg_acc(1'b0, 9'h102, 32'h0, r, e, y);
    checks++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL err_102_rd: got err=%b rdata=%h want 1 0", e, r); else passed++;
    cfg_acc(1'b0, 9'h014, 32'h0, r, e, y);
    checks++; if (e !== 1'b1) $display("FAIL err_off14: got err=%b want 1", e); else passed++;
    cfg_acc(1'b1, 9'h011, 32'h0, r, e, y);
    checks++; if (e !== 1'b1) $display("FAIL err_misaligned_wr: got err=%b want 1", e); else passed++;
    rd(9'h010, r);
    checks++; if (r !== 32'h8000_0009) $display("FAIL err_shadow_kept: got %h want 80000009", r); else passed++;
    cfg_acc(1'b1, 9'h0C0, 32'h0000_1234, r, e, y);
    checks++; if (e !== 1'b0) $display("FAIL rule6_ok: got err=%b want 0", e); else passed++;
    rd(9'h0C0, r);
    checks++; if (r !== 32'h0000_1234) $display("FAIL rule6_rb: got %h want 1234", r); else passed++;
    wr(9'h0C4, 32'hFFFF_FFFF);
    rd(9'h0C4, r);
    checks++; if (r !== 32'h0000_FFFF) $display("FAIL hi_bits_zero: got %h want 0000ffff", r); else passed++;
  endtask

  task automatic test_swap_stall();
    logic [31:0] r; int p0;
    p0 = pulses;
    wr(9'h100, 32'h1);
    @(negedge clk_i);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_write_i = 1'b1; cfg_addr_i = 9'h0D0; cfg_wdata_i = 32'h8000_000A;
    #1;
    checks++; if (cfg_ready_o !== 1'b0) $display("FAIL swap_stall: got ready=%b want 0", cfg_ready_o); else passed++;
    @(posedge clk_i); #1;
    checks++; if (commit_done_o !== 1'b1) $display("FAIL swap_done_pulse: got %b want 1", commit_done_o); else passed++;
    checks++; if (cfg_ready_o !== 1'b1) $display("FAIL swap_release: got ready=%b want 1", cfg_ready_o); else passed++;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_write_i = 1'b0;
    rd(9'h0D0, r);
    checks++; if (r !== 32'h8000_000A) $display("FAIL swap_late_write: got %h want 8000000a", r); else passed++;
    repeat (4) @(posedge clk_i); #1;
    checks++; if (pulses - p0 !== 1) $display("FAIL swap_pulses: got %0d want 1", pulses - p0); else passed++;
  endtask

  task automatic test_backpressure();
    dec_out_ready_i = 1'b0;
    @(negedge clk_i);
    dec_valid_i = 1'b1; dec_addr_i = 48'h0000_0000_1000;
    @(posedge clk_i); #1;
    dec_addr_i = 48'h0000_9000_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      checks++; if (dec_out_valid_o !== 1'b1 || dec_idx_o !== 4'd5 || dec_err_o !== 1'b0)
        $display("FAIL bp_hold_c%0d: got vld=%b idx=%0d err=%b want 1 5 0", c, dec_out_valid_o, dec_idx_o, dec_err_o); else passed++;
      checks++; if (dec_ready_o !== 1'b0) $display("FAIL bp_ready_c%0d: got %b want 0", c, dec_ready_o); else passed++;
    end
    dec_valid_i = 1'b0; dec_out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (dec_out_valid_o !== 1'b0) $display("FAIL bp_release: got vld=%b want 0", dec_out_valid_o); else passed++;
    send_done();
  endtask

  task automatic test_max_outstanding();
    logic [3:0] i; logic e; logic [31:0] r;
    for (int k = 0; k < 15; k++) do_decode(48'h0000_0000_1000, i, e);
    rd(9'h104, r);
    checks++; if (r !== 32'h0F00) $display("FAIL max_status15: got %h want f00", r); else passed++;
    dec_out_ready_i = 1'b0;
    @(negedge clk_i);
    dec_valid_i = 1'b1; dec_addr_i = 48'h0000_9000_0000;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    dec_out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dec_valid_i = 1'b0; dec_out_ready_i = 1'b0;
    checks++; if (dec_out_valid_o !== 1'b1 || dec_idx_o !== 4'd9) $display("FAIL max_17th: got vld=%b idx=%0d want 1 9", dec_out_valid_o, dec_idx_o); else passed++;
    @(negedge clk_i);
    dec_out_ready_i = 1'b1; #1;
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL max_ready_low: got %b want 0", dec_ready_o); else passed++;
    dec_out_ready_i = 1'b0;
    rd(9'h104, r);
    checks++; if (r !== 32'h1000) $display("FAIL max_status16: got %h want 1000", r); else passed++;
    @(negedge clk_i);
    dec_out_ready_i = 1'b1; done_i = 1'b1;
    @(posedge clk_i); #1;
    done_i = 1'b0;
    rd(9'h104, r);
    checks++; if (r !== 32'h1000) $display("FAIL max_simul: got %h want 1000", r); else passed++;
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL max_ready_still_low: got %b want 0", dec_ready_o); else passed++;
    for (int k = 0; k < 16; k++) send_done();
    rd(9'h104, r);
    checks++; if (r !== 32'h0) $display("FAIL max_drained: got %h want 0", r); else passed++;
    send_done();
    rd(9'h104, r);
    checks++; if (r !== 32'h0) $display("FAIL done_at_zero: got %h want 0", r); else passed++;
    checks++; if (dec_ready_o !== 1'b1) $display("FAIL max_ready_back: got %b want 1", dec_ready_o); else passed++;
  endtask

  task automatic test_reset_mid_commit();
    logic [3:0] i; logic e; logic [31:0] r; int p0;
    do_decode(48'h0000_0000_1000, i, e);
    wr(9'h100, 32'h1);
    rd(9'h104, r);
    checks++; if (r !== 32'h101) $display("FAIL rmc_pending: got %h want 101", r); else passed++;
    p0 = pulses;
    @(negedge clk_i); rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    repeat (6) @(posedge clk_i); #1;
    checks++; if (pulses - p0 !== 0) $display("FAIL rmc_no_pulse: got %0d want 0", pulses - p0); else passed++;
    rd(9'h104, r);
    checks++; if (r !== 32'h0) $display("FAIL rmc_status: got %h want 0", r); else passed++;
    rd(9'h010, r);
    checks++; if (r !== 32'h0) $display("FAIL rmc_shadow_clear: got %h want 0", r); else passed++;
    checks++; if (dec_ready_o !== 1'b1) $display("FAIL rmc_ready: got %b want 1", dec_ready_o); else passed++;
    do_decode(48'h0000_9000_0000, i, e); send_done();
    checks++; if (i !== 4'd0 || e !== 1'b1) $display("FAIL rmc_active_clear: got idx=%0d err=%b want idx=0 err=1", i, e); else passed++;
  endtask

  initial begin
    rst_i = 1'b1;
    cfg_valid_i = 1'b0; cfg_write_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
    dec_valid_i = 1'b0; dec_addr_i = '0; dec_out_ready_i = 1'b1; done_i = 1'b0;
    test_reset();
    test_default_decode();
    test_rule_match();
    test_overlap();
    test_commit_drain();
    test_cfg_error();
    test_swap_stall();
    test_backpressure();
    test_max_outstanding();
    test_reset_mid_commit();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
